// File: rtl/stream_ser_pkg.sv
// Shared helpers for the stream serializer: length-field width and beat-count clamp.
package stream_ser_pkg;

  // Width of a field able to hold 0..MAXB inclusive.
  function automatic int lenw(input int inwidth, input int outwidth);
    return $clog2(inwidth / outwidth) + 1;
  endfunction

  function automatic int min_len(input int len, input int maxb);
    return (len > maxb) ? maxb : len;
  endfunction

endpackage

// File: rtl/stream_serializer_if.sv
// Word-in / beat-out stream bundle; master is the producer side, slave is the serializer.
interface stream_serializer_if
  import stream_ser_pkg::*;
#(
  parameter int INWIDTH  = 256,
  parameter int OUTWIDTH = 8
);
  logic [INWIDTH-1:0]                   in_data;
  logic [lenw(INWIDTH, OUTWIDTH)-1:0]   in_len;
  logic                                 in_valid;
  logic                                 in_ready;
  logic [OUTWIDTH-1:0]                  out_data;
  logic                                 out_valid;
  logic                                 out_ready;
  logic                                 out_last;

  modport master (
    output in_data, in_len, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_len, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/ser_shift_unit.sv
// Shift register, beat counter and output slice select for the stream serializer.
module ser_shift_unit
  import stream_ser_pkg::*;
#(
  parameter int INWIDTH   = 256,
  parameter int OUTWIDTH  = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               load,
  input  logic [INWIDTH-1:0]                 load_data,
  input  logic [lenw(INWIDTH, OUTWIDTH)-1:0] load_len,
  input  logic                               beat_ready,
  output logic [OUTWIDTH-1:0]                out_data,
  output logic                               out_valid,
  output logic                               out_last
);
  localparam int MAXB = INWIDTH / OUTWIDTH;
  localparam int LENW = lenw(INWIDTH, OUTWIDTH);

  logic [INWIDTH-1:0]  shift_q, shift_d;
  logic [LENW-1:0]     cnt_q, cnt_d;
  logic [OUTWIDTH-1:0] head;

  assign out_valid = (cnt_q != '0);
  assign out_last  = (cnt_q == LENW'(1));
  assign head      = (MSB_FIRST != 0) ? shift_q[INWIDTH-1 -: OUTWIDTH]
                                      : shift_q[OUTWIDTH-1:0];
  assign out_data  = out_valid ? head : '0;

  // A load always coincides with an idle counter or the last beat leaving,
  // so it takes priority over the shift.
  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (load) begin
      shift_d = load_data;
      cnt_d   = LENW'(min_len(int'(load_len), MAXB));
    end else if (out_valid && beat_ready) begin
      shift_d = (MSB_FIRST != 0) ? (shift_q << OUTWIDTH) : (shift_q >> OUTWIDTH);
      cnt_d   = cnt_q - LENW'(1);
    end
  end

  // NOTE: state updates use <= only; next-state math lives in always_comb.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/stream_serializer.sv
// Parallel-word to narrow-beat serializer with a one-entry pending buffer in front.
module stream_serializer
  import stream_ser_pkg::*;
#(
  parameter int INWIDTH   = 256,
  parameter int OUTWIDTH  = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [INWIDTH-1:0]                 in_data,
  input  logic [lenw(INWIDTH, OUTWIDTH)-1:0] in_len,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [OUTWIDTH-1:0]                out_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               out_last
);
  localparam int LENW = lenw(INWIDTH, OUTWIDTH);

  if (INWIDTH % OUTWIDTH != 0) begin : g_width_check
    $error("stream_serializer: INWIDTH must be an integer multiple of OUTWIDTH");
  end

  logic               pend_valid_q, pend_valid_d;
  logic [INWIDTH-1:0] pend_data_q, pend_data_d;
  logic [LENW-1:0]    pend_len_q, pend_len_d;
  logic               accept;
  logic               move;

  // in_ready comes straight from a flop, so out_ready never reaches it.
  assign in_ready = ~pend_valid_q;
  assign accept   = in_valid && in_ready;
  assign move     = pend_valid_q && (!out_valid || (out_last && out_ready));

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    pend_len_d   = pend_len_q;
    if (move) begin
      pend_valid_d = 1'b0;
    end
    if (accept) begin
      pend_valid_d = 1'b1;
      pend_data_d  = in_data;
      pend_len_d   = in_len;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_valid_q <= 1'b0;
    end else begin
      pend_valid_q <= pend_valid_d;
    end
  end

  // NOTE: payload is qualified by pend_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    pend_data_q <= pend_data_d;
    pend_len_q  <= pend_len_d;
  end

  ser_shift_unit #(
    .INWIDTH  (INWIDTH),
    .OUTWIDTH (OUTWIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shift (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (move),
    .load_data (pend_data_q),
    .load_len  (pend_len_q),
    .beat_ready(out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_stream_serializer.sv
// Bench for stream_serializer: LSB-first and MSB-first instances share one stimulus stream.
module tb_stream_serializer;
  import stream_ser_pkg::*;

  localparam int INW  = 32;
  localparam int OUTW = 8;
  localparam int LW   = lenw(INW, OUTW);
  localparam int MAXB = INW / OUTW;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         cyc;
  } beat_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  typedef struct {
    logic [31:0]   data;
    logic [LW-1:0] len;
    int            n;
    logic [63:0]   exp_l;
    logic [63:0]   exp_m;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  stream_serializer_if #(.INWIDTH(INW), .OUTWIDTH(OUTW)) ifl ();
  stream_serializer_if #(.INWIDTH(INW), .OUTWIDTH(OUTW)) ifm ();

  stream_serializer #(.INWIDTH(INW), .OUTWIDTH(OUTW), .MSB_FIRST(0)) dut_l (
    .clk(clk), .reset_n(reset_n),
    .in_data(ifl.in_data), .in_len(ifl.in_len), .in_valid(ifl.in_valid), .in_ready(ifl.in_ready),
    .out_data(ifl.out_data), .out_valid(ifl.out_valid), .out_ready(ifl.out_ready),
    .out_last(ifl.out_last)
  );

  stream_serializer #(.INWIDTH(INW), .OUTWIDTH(OUTW), .MSB_FIRST(1)) dut_m (
    .clk(clk), .reset_n(reset_n),
    .in_data(ifm.in_data), .in_len(ifm.in_len), .in_valid(ifm.in_valid), .in_ready(ifm.in_ready),
    .out_data(ifm.out_data), .out_valid(ifm.out_valid), .out_ready(ifm.out_ready),
    .out_last(ifm.out_last)
  );

  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;
  int    last_acc_cyc = 0;
  beat_t got_l[$];
  beat_t got_m[$];
  exp_t  exp_l[$];
  exp_t  exp_m[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got event missing, expected event seen (cycle %0d)", name, cyc);
  endtask

  task automatic set_in(input logic v, input logic [31:0] d, input logic [LW-1:0] l);
    ifl.in_valid = v; ifl.in_data = d; ifl.in_len = l;
    ifm.in_valid = v; ifm.in_data = d; ifm.in_len = l;
  endtask

  task automatic set_ready(input logic r);
    ifl.out_ready = r;
    ifm.out_ready = r;
  endtask

  // Reference model: a word of length L yields min(L, MAXB) byte slices,
  // taken from the low end upward (LSB-first) or from the high end downward.
  task automatic model_push(input logic [31:0] w, input logic [LW-1:0] l);
    int          n;
    logic [31:0] lo;
    logic [31:0] hi;
    exp_t        e;
    n = (int'(l) > MAXB) ? MAXB : int'(l);
    for (int i = 0; i < n; i++) begin
      lo = w >> (8 * i);
      hi = w >> (8 * (MAXB - 1 - i));
      e.last = (i == n - 1);
      e.data = lo[7:0]; exp_l.push_back(e);
      e.data = hi[7:0]; exp_m.push_back(e);
    end
  endtask

  task automatic score(input bit msb, input logic v, input logic r, input logic [7:0] d,
                       input logic last);
    exp_t  e;
    beat_t b;
    int    depth;
    if (!v) begin
      check(msb ? "idle_data_m" : "idle_data_l", 32'(d), 32'h0);
      check(msb ? "idle_last_m" : "idle_last_l", 32'(last), 32'h0);
    end else if (r) begin
      b.data = d; b.last = last; b.cyc = cyc;
      if (msb) got_m.push_back(b); else got_l.push_back(b);
      depth = msb ? exp_m.size() : exp_l.size();
      if (depth == 0) begin
        fail(msb ? "sb_extra_beat_m" : "sb_extra_beat_l");
      end else begin
        if (msb) e = exp_m.pop_front(); else e = exp_l.pop_front();
        check(msb ? "sb_data_m" : "sb_data_l", 32'(d), 32'(e.data));
        check(msb ? "sb_last_m" : "sb_last_l", 32'(last), 32'(e.last));
      end
    end
  endtask

  // Samples the settled outputs, then advances to the next falling edge.
  task automatic cycle();
    if (reset_n) begin
      score(1'b0, ifl.out_valid, ifl.out_ready, ifl.out_data, ifl.out_last);
      score(1'b1, ifm.out_valid, ifm.out_ready, ifm.out_data, ifm.out_last);
      if (ifl.in_valid && ifl.in_ready) begin
        model_push(ifl.in_data, ifl.in_len);
        last_acc_cyc = cyc;
      end
    end else begin
      exp_l.delete();
      exp_m.delete();
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    set_in(1'b0, 32'h0, '0);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic send_word(input logic [31:0] d, input logic [LW-1:0] l);
    bit done;
    done = 1'b0;
    set_in(1'b1, d, l);
    for (int k = 0; k < 20 && !done; k++) begin
      done = ifl.in_ready;
      cycle();
    end
    if (!done) fail("send_timeout");
    set_in(1'b0, 32'h0, '0);
  endtask

  task automatic clear_got();
    got_l.delete();
    got_m.delete();
  endtask

  task automatic check_beats(input string tag, input bit msb, input int n, input logic [63:0] exp,
                             input logic [7:0] last_mask, input bit contig);
    beat_t       q[$];
    logic [63:0] sh;
    if (msb) q = got_m; else q = got_l;
    check($sformatf("%s_count", tag), 32'(q.size()), 32'(n));
    for (int i = 0; i < n && i < q.size(); i++) begin
      sh = exp >> (8 * (7 - i));
      check($sformatf("%s_data%0d", tag, i), 32'(q[i].data), 32'(sh[7:0]));
      check($sformatf("%s_last%0d", tag, i), 32'(q[i].last), 32'(last_mask[i]));
      if (contig && i > 0)
        check($sformatf("%s_gap%0d", tag, i), 32'(q[i].cyc - q[i-1].cyc), 32'd1);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid_l"}, 32'(ifl.out_valid), 32'h0);
    check({tag, "_data_l"},  32'(ifl.out_data),  32'h0);
    check({tag, "_last_l"},  32'(ifl.out_last),  32'h0);
    check({tag, "_ready_l"}, 32'(ifl.in_ready),  32'h1);
    check({tag, "_valid_m"}, 32'(ifm.out_valid), 32'h0);
    check({tag, "_ready_m"}, 32'(ifm.in_ready),  32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       vecs[7];
    logic [7:0] mask;
    bit         stalled;

    vecs[0] = '{32'hA1B2C3D4, 3'd4, 4, 64'hD4C3B2A1_00000000, 64'hA1B2C3D4_00000000};
    vecs[1] = '{32'h11223344, 3'd2, 2, 64'h44330000_00000000, 64'h11220000_00000000};
    vecs[2] = '{32'h55667788, 3'd7, 4, 64'h88776655_00000000, 64'h55667788_00000000};
    vecs[3] = '{32'hDEADBEEF, 3'd1, 1, 64'hEF000000_00000000, 64'hDE000000_00000000};
    vecs[4] = '{32'h01020304, 3'd3, 3, 64'h04030200_00000000, 64'h01020300_00000000};
    vecs[5] = '{32'hFFFFFFFF, 3'd0, 0, 64'h0,                 64'h0};
    vecs[6] = '{32'h0F1E2D3C, 3'd5, 4, 64'h3C2D1E0F_00000000, 64'h0F1E2D3C_00000000};

    set_in(1'b0, 32'h0, '0);
    set_ready(1'b1);
    reset_n = 1'b0;
    cycle();
    cycle();
    reset_n = 1'b1;
    check_idle("reset");

    // Single words with the sink always ready: order, last flag, latency, no gaps.
    foreach (vecs[v]) begin
      clear_got();
      send_word(vecs[v].data, vecs[v].len);
      idle(8);
      mask = (vecs[v].n > 0) ? 8'(1 << (vecs[v].n - 1)) : 8'h0;
      check_beats($sformatf("vec%0d_l", v), 1'b0, vecs[v].n, vecs[v].exp_l, mask, 1'b1);
      check_beats($sformatf("vec%0d_m", v), 1'b1, vecs[v].n, vecs[v].exp_m, mask, 1'b1);
      if (got_l.size() > 0)
        check($sformatf("vec%0d_latency", v), 32'(got_l[0].cyc - last_acc_cyc), 32'd2);
    end

    // Back-pressure for two cycles while C3 is presented by the LSB-first instance.
    clear_got();
    send_word(32'hA1B2C3D4, 3'd4);
    stalled = 1'b0;
    for (int k = 0; k < 12 && !stalled; k++) begin
      if (ifl.out_valid && ifl.out_data == 8'hC3) begin
        stalled = 1'b1;
        set_ready(1'b0);
        cycle();
        check("hold1_data",  32'(ifl.out_data),  32'hC3);
        check("hold1_valid", 32'(ifl.out_valid), 32'h1);
        check("hold1_last",  32'(ifl.out_last),  32'h0);
        cycle();
        check("hold2_data",  32'(ifl.out_data),  32'hC3);
        check("hold2_valid", 32'(ifl.out_valid), 32'h1);
        set_ready(1'b1);
      end
      cycle();
    end
    if (!stalled) fail("hold_c3_seen");
    idle(8);
    check_beats("hold_l", 1'b0, 4, 64'hD4C3B2A1_00000000, 8'b1000, 1'b0);
    check_beats("hold_m", 1'b1, 4, 64'hA1B2C3D4_00000000, 8'b1000, 1'b0);

    // Zero-length word discarded, then a short word and a clamped word.
    clear_got();
    send_word(32'h0, 3'd0);
    send_word(32'h11223344, 3'd2);
    send_word(32'h55667788, 3'd7);
    idle(12);
    check_beats("seq_l", 1'b0, 6, 64'h44338877_66550000, 8'b0010_0010, 1'b0);
    check_beats("seq_m", 1'b1, 6, 64'h11225566_77880000, 8'b0010_0010, 1'b0);

    // Back-to-back two-beat words stream without a bubble.
    clear_got();
    send_word(32'hCAFEF00D, 3'd2);
    check("b2b_in_ready_full1", 32'(ifl.in_ready), 32'h0);
    send_word(32'h12345678, 3'd2);
    check("b2b_in_ready_full2", 32'(ifl.in_ready), 32'h0);
    idle(8);
    check_beats("b2b_l", 1'b0, 4, 64'h0DF07856_00000000, 8'b1010, 1'b1);
    check_beats("b2b_m", 1'b1, 4, 64'hCAFE1234_00000000, 8'b1010, 1'b1);

    // Reset after the second beat abandons the rest of the word.
    clear_got();
    send_word(32'hA1B2C3D4, 3'd4);
    for (int k = 0; k < 10 && got_l.size() < 2; k++) cycle();
    if (got_l.size() < 2) fail("mid_reset_two_beats");
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    check_idle("mid_reset");
    idle(8);
    check("mid_reset_beats_l", 32'(got_l.size()), 32'd2);
    check("mid_reset_beats_m", 32'(got_m.size()), 32'd2);

    // Random traffic against the model, with occasional resets.
    for (int k = 0; k < 400; k++) begin
      set_in($urandom_range(0, 9) < 7, $urandom, LW'($urandom_range(0, 7)));
      set_ready($urandom_range(0, 3) != 0);
      reset_n = ($urandom_range(0, 199) != 0);
      cycle();
    end
    reset_n = 1'b1;
    set_ready(1'b1);
    idle(20);
    check("drain_l", 32'(exp_l.size()), 32'd0);
    check("drain_m", 32'(exp_m.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stream_serializer.md
STREAM_SERIALIZER -- requirements
Module: stream_serializer

Interface
REQ-001 The block SHALL have parameter INWIDTH, default 256, meaning input word width in bits.
REQ-002 The block SHALL have parameter OUTWIDTH, default 8, meaning output beat width in bits.
REQ-003 The block SHALL have parameter MSB_FIRST, default 0, meaning 0 = low slice first, 1 = high slice first.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port in_data, input, INWIDTH bits: parallel word.
REQ-007 The block SHALL have port in_len, input, LENW = $clog2(INWIDTH/OUTWIDTH)+1 bits: beats to emit for this word.
REQ-008 The block SHALL have port in_valid, input, 1 bit: word offered.
REQ-009 The block SHALL have port in_ready, output, 1 bit: word accepted when in_valid && in_ready.
REQ-010 The block SHALL have port out_data, output, OUTWIDTH bits: current beat.
REQ-011 The block SHALL have port out_valid, output, 1 bit: beat present.
REQ-012 The block SHALL have port out_ready, input, 1 bit: beat consumed when out_valid && out_ready.
REQ-013 The block SHALL have port out_last, output, 1 bit: final beat of the current word.

Function
REQ-014 The block SHALL treat INWIDTH not an integer multiple of OUTWIDTH as an elaboration error; define MAXB = INWIDTH/OUTWIDTH.
REQ-015 The block SHALL hold one pending entry (data, length, valid flag), and in_ready SHALL equal the inverted pending-valid flag, registered with no combinational path from out_ready.
REQ-016 The block SHALL hold a shift register and a beat counter cnt, and out_valid SHALL equal (cnt != 0).
REQ-017 The block SHALL move the pending entry into the shift register on an edge where pending is valid and either cnt == 0 or the last beat (cnt == 1) is consumed; pending-valid clears on the same edge unless a new word is accepted on it.
REQ-018 On a move, cnt SHALL load min(in_len, MAXB); in_len > MAXB SHALL clamp to MAXB.
REQ-019 A word with in_len == 0 SHALL be accepted and discarded on move, producing no beat.
REQ-020 Latency SHALL be: word accepted at edge N, with the shift register idle, gives out_valid high after edge N+1.
REQ-021 With MSB_FIRST=0, out_data SHALL be shift_reg[OUTWIDTH-1:0] and each consumed beat SHALL shift right by OUTWIDTH, zero-filling.
REQ-022 With MSB_FIRST=1, out_data SHALL be shift_reg[INWIDTH-1 -: OUTWIDTH] and each consumed beat SHALL shift left by OUTWIDTH, zero-filling.
REQ-023 Each consumed beat SHALL decrement cnt by 1, and cnt SHALL never wrap below 0.
REQ-024 While out_valid && !out_ready, out_data, out_last and cnt SHALL hold stable (no beat lost or repeated).
REQ-025 out_last SHALL equal (cnt == 1), and out_data SHALL be forced to 0 when out_valid is low.
REQ-026 With out_ready held high, throughput SHALL be one beat per cycle with no inter-word bubble for in_len >= 2; in_len == 1 words SHALL sustain one word per 2 cycles.
REQ-027 Simultaneous accept and move on one edge SHALL write the new word into pending while the old pending word moves to the shift register.

Reset
REQ-028 With reset_n low at a rising clk edge, the block SHALL clear cnt, pending-valid and shift_reg, overriding any handshake on that edge.
REQ-029 After the reset edge, outputs SHALL be: out_valid=0, out_last=0, out_data=0, in_ready=1.
REQ-030 Reset mid-word SHALL abandon the in-flight and pending words with no further beats emitted.

Structure
REQ-031 A shared package stream_ser_pkg SHALL hold the LENW width function and the beat-count helper min_len(len, maxb).
REQ-032 The shift register, counter and slice-select datapath SHALL be a sub-module ser_shift_unit (parameters INWIDTH, OUTWIDTH, MSB_FIRST).
REQ-033 The top SHALL own the pending entry and the handshake logic.

Verification (INWIDTH=32, OUTWIDTH=8)
REQ-034 Bench SHALL check: MSB_FIRST=0, in_data=0xA1B2C3D4, in_len=4, out_ready=1 -> beats D4,C3,B2,A1 on consecutive cycles, out_last only on A1.
REQ-035 Bench SHALL check: MSB_FIRST=1, same word -> beats A1,B2,C3,D4, out_last on D4.
REQ-036 Bench SHALL check: out_ready low for 2 cycles while C3 is presented -> C3 held stable, then B2,A1 follow, 4 beats total.
REQ-037 Bench SHALL check: in_len=0 word, then 0x11223344 with in_len=2, then 0x55667788 with in_len=7 -> beats 44,33,88,77,66,55 (clamped to 4).
REQ-038 Bench SHALL check: two back-to-back words, in_len=2, out_ready=1 -> 4 consecutive beats with no gap, and in_ready=0 while pending is full.
REQ-039 Bench SHALL check: reset_n low for 1 cycle after the 2nd beat of a 4-beat word -> next cycle out_valid=0, out_data=0, in_ready=1, with no further beats.
